// File: rtl/hspi_receiver_pkg.sv
// hspi_receiver_pkg
//   Shared definitions for the HSPI receive endpoint: FSM state encoding,
//   header field layout, CRC-32 constants and small helper functions.
package hspi_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Header word layout: [31:30] sync, [29:26] sequence, [25:0] reserved (zero)
  localparam logic [1:0]  HDR_SYNC     = 2'b11;
  localparam int          HDR_SYNC_HI  = 31;
  localparam int          HDR_SYNC_LO  = 30;
  localparam int          HDR_SEQ_HI   = 29;
  localparam int          HDR_SEQ_LO   = 26;
  localparam int          HDR_RSVD_HI  = 25;

  localparam logic [31:0] CRC_POLY     = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;

  function automatic logic [31:0] bit_rev32(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = d[31-i];
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hspi_receiver_crc32.sv
// crc32_32b
//   Combinational 32-bit-parallel CRC-32 update (MSB-first, non-reflected).
//   Any bit reflection or final inversion is left to the caller.
// Ports:
//   i_crc  - current CRC register
//   i_data - 32-bit data word, i_data[31] is shifted in first
//   o_crc  - CRC register after absorbing i_data
module crc32_32b
  import hspi_receiver_pkg::*;
#(
  parameter logic [31:0] POLY = CRC_POLY
) (
  input  logic [31:0] i_crc,
  input  logic [31:0] i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_crc;

  always_comb begin
    w_crc = i_crc;
    for (int i = 31; i >= 0; i--) begin
      if (w_crc[31] ^ i_data[i]) w_crc = {w_crc[30:0], 1'b0} ^ POLY;
      else                       w_crc = {w_crc[30:0], 1'b0};
    end
    o_crc = w_crc;
  end

endmodule

// File: rtl/hspi_receiver.sv
// hspi_receiver
//   Receive endpoint of the 32-bit HSPI link. Accepts header + PAYLOAD_LEN
//   payload words + CRC-32 word, forwards payload to a downstream FIFO,
//   checks header, sequence number and CRC, and reports per-packet status.
// Ports:
//   sys_clk, sys_rst            - clock, synchronous active-high reset
//   hrreq / hrrdy               - transmitter request / receiver grant
//   hrvld, hrd                  - link word strobe and data
//   hspi_cts                    - clear-to-send (active low), registered fifo_afull
//   fifo_afull, fifo_full       - downstream FIFO status
//   fifo_wr_en, fifo_wr_data    - downstream FIFO write port
//   pkt_done + pkt_crc_ok/pkt_seq_ok/pkt_abort - end-of-packet pulse and flags
//   rx_seq                      - sequence number of the last good header
//   pkt_cnt, err_cnt            - saturating good/bad packet counters
//   ovf                         - sticky payload-drop flag
module hspi_receiver
  import hspi_receiver_pkg::*;
#(
  parameter int PAYLOAD_LEN = 4,
  parameter int REQ_TIMEOUT = 25_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        hrreq,
  output logic        hrrdy,
  input  logic        hrvld,
  input  logic [31:0] hrd,
  output logic        hspi_cts,
  input  logic        fifo_afull,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_wr_data,
  output logic        pkt_done,
  output logic        pkt_crc_ok,
  output logic        pkt_seq_ok,
  output logic        pkt_abort,
  output logic [3:0]  rx_seq,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt,
  output logic        ovf
);

  localparam int CNT_W = $clog2(PAYLOAD_LEN + 1);
  localparam int TO_W  = $clog2(REQ_TIMEOUT + 1);

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [31:0]       r_crc;
  logic              r_seq_known;
  logic              r_seq_ok;

  logic              w_hdr_acc, w_pay_acc, w_crc_acc, w_abort;
  logic              w_hdr_ok, w_seq_match, w_timeout, w_last_word, w_crc_match;
  logic [31:0]       w_crc_nxt, w_crc_final;

  crc32_32b #(.POLY(CRC_POLY)) u_crc (
    .i_crc  (r_crc),
    .i_data (bit_rev32(hrd)),
    .o_crc  (w_crc_nxt)
  );

  assign w_crc_final = ~bit_rev32(r_crc);
  assign w_crc_match = (hrd == w_crc_final);
  assign w_hdr_ok    = (hrd[HDR_SYNC_HI:HDR_SYNC_LO] == HDR_SYNC) &&
                       (hrd[HDR_RSVD_HI:0] == '0);
  // First header after reset has no reference, so it always matches
  assign w_seq_match = !r_seq_known ||
                       (hrd[HDR_SEQ_HI:HDR_SEQ_LO] == rx_seq + 4'd1);
  // This cycle would be the REQ_TIMEOUT-th consecutive cycle without a word
  assign w_timeout   = !hrvld && (r_to_cnt == TO_W'(REQ_TIMEOUT - 1));
  assign w_last_word = (r_word_cnt == CNT_W'(PAYLOAD_LEN - 1));

  always_comb begin
    w_next    = r_state;
    w_hdr_acc = 1'b0;
    w_pay_acc = 1'b0;
    w_crc_acc = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (hrreq) w_next = ST_GRANT;
      end
      ST_GRANT: begin
        if (!hrreq) begin
          w_abort = 1'b1;
          w_next  = ST_DONE;
        end else if (hrvld) begin
          if (w_hdr_ok) begin
            w_hdr_acc = 1'b1;
            w_next    = ST_PAYLOAD;
          end else begin
            w_abort = 1'b1;
            w_next  = ST_DONE;
          end
        end else if (w_timeout) begin
          w_abort = 1'b1;
          w_next  = ST_DONE;
        end
      end
      ST_PAYLOAD: begin
        if (!hrreq) begin
          w_abort = 1'b1;
          w_next  = ST_DONE;
        end else if (hrvld) begin
          w_pay_acc = 1'b1;
          if (w_last_word) w_next = ST_CRC;
        end else if (w_timeout) begin
          w_abort = 1'b1;
          w_next  = ST_DONE;
        end
      end
      ST_CRC: begin
        if (!hrreq) begin
          w_abort = 1'b1;
          w_next  = ST_DONE;
        end else if (hrvld) begin
          w_crc_acc = 1'b1;
          w_next    = ST_DONE;
        end else if (w_timeout) begin
          w_abort = 1'b1;
          w_next  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!hrreq) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= ST_IDLE;
      r_word_cnt   <= '0;
      r_to_cnt     <= '0;
      r_crc        <= CRC_INIT;
      r_seq_known  <= 1'b0;
      r_seq_ok     <= 1'b0;
      hrrdy        <= 1'b0;
      hspi_cts     <= 1'b1;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      pkt_done     <= 1'b0;
      pkt_crc_ok   <= 1'b0;
      pkt_seq_ok   <= 1'b0;
      pkt_abort    <= 1'b0;
      rx_seq       <= '0;
      pkt_cnt      <= '0;
      err_cnt      <= '0;
      ovf          <= 1'b0;
    end else begin
      r_state    <= w_next;
      hspi_cts   <= fifo_afull;
      hrrdy      <= (w_next == ST_GRANT) || (w_next == ST_PAYLOAD) ||
                    (w_next == ST_CRC);
      fifo_wr_en <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_crc_ok <= 1'b0;
      pkt_seq_ok <= 1'b0;
      pkt_abort  <= 1'b0;

      // Idle-cycle count only runs while a packet is in flight
      if (((r_state == ST_GRANT) || (r_state == ST_PAYLOAD) ||
           (r_state == ST_CRC)) && !hrvld)
        r_to_cnt <= r_to_cnt + TO_W'(1);
      else
        r_to_cnt <= '0;

      if (r_state == ST_IDLE) begin
        r_word_cnt <= '0;
        r_crc      <= CRC_INIT;
        r_seq_ok   <= 1'b0;
      end

      if (w_hdr_acc) begin
        r_crc       <= w_crc_nxt;
        rx_seq      <= hrd[HDR_SEQ_HI:HDR_SEQ_LO];
        r_seq_known <= 1'b1;
        r_seq_ok    <= w_seq_match;
      end

      if (w_pay_acc) begin
        r_crc      <= w_crc_nxt;
        r_word_cnt <= r_word_cnt + CNT_W'(1);
        if (fifo_full) begin
          ovf <= 1'b1;
        end else begin
          fifo_wr_en   <= 1'b1;
          fifo_wr_data <= hrd;
        end
      end

      if (w_crc_acc || w_abort) begin
        pkt_done   <= 1'b1;
        pkt_crc_ok <= w_crc_acc && w_crc_match;
        pkt_seq_ok <= r_seq_ok;
        pkt_abort  <= w_abort;
        if (w_crc_acc && w_crc_match && r_seq_ok) pkt_cnt <= sat_inc16(pkt_cnt);
        else                                      err_cnt <= sat_inc16(err_cnt);
      end
    end
  end

endmodule
